// File: rtl/systolic_ws_controller.sv
`default_nettype none
// ============================================================================
// Module  : systolic_ws_controller
// Brief   : Weight-stationary systolic array sequencer: stages and shifts a
//           weight tile, streams a tagged activation batch, drains results.
// Revision: 1.0 - initial release
// ============================================================================
module systolic_ws_controller #(
    parameter int ARRWIDTH  = 8,
    parameter int ARRHEIGHT = 8,
    parameter int WORDWIDTH = 8,
    parameter int LATENCY   = 17,
    parameter int CNTWIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [CNTWIDTH-1:0]               num_vecs,
    output logic                              busy,
    output logic                              done,
    input  logic                              w_valid,
    output logic                              w_ready,
    input  logic [WORDWIDTH*ARRWIDTH-1:0]     w_data,
    input  logic                              a_valid,
    output logic                              a_ready,
    input  logic [WORDWIDTH*ARRHEIGHT-1:0]    a_data,
    output logic                              res_valid,
    output logic [4*WORDWIDTH*ARRWIDTH-1:0]   res_data,
    output logic                              arr_mode,
    output logic [WORDWIDTH*ARRWIDTH-1:0]     arr_w_in_vec,
    output logic [WORDWIDTH*ARRHEIGHT-1:0]    arr_a_in_vec,
    input  logic [4*WORDWIDTH*ARRWIDTH-1:0]   arr_ps_out_vec
);

    localparam int c_IW = (ARRHEIGHT > 1) ? $clog2(ARRHEIGHT) : 1;
    localparam int c_DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_IW-1:0] c_ROW_LAST   = c_IW'(ARRHEIGHT - 1);
    localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(LATENCY - 1);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_LOAD_W  = 3'd1;
    localparam logic [2:0] c_S_SHIFT_W = 3'd2;
    localparam logic [2:0] c_S_COMPUTE = 3'd3;
    localparam logic [2:0] c_S_DRAIN   = 3'd4;
    localparam logic [2:0] c_S_DONE    = 3'd5;

    logic [2:0]                       r_state;
    logic [CNTWIDTH-1:0]              r_vec_total;
    logic [CNTWIDTH-1:0]              r_vec_cnt;
    logic [c_IW-1:0]                  r_row_cnt;
    logic [c_IW-1:0]                  r_shift_cnt;
    logic [c_DW-1:0]                  r_drain_cnt;
    logic [LATENCY-1:0]               r_tag;
    logic [WORDWIDTH*ARRWIDTH-1:0]    r_wbuf [ARRHEIGHT];

    logic w_tag_in;
    logic w_advance;

    assign w_tag_in  = (r_state == c_S_COMPUTE) && a_valid;
    assign w_advance = (r_state == c_S_COMPUTE) || (r_state == c_S_DRAIN);
    assign res_data  = arr_ps_out_vec;

    // Outputs are forced low while reset is asserted so an abort is visible at once.
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        w_ready      = 1'b0;
        a_ready      = 1'b0;
        arr_mode     = 1'b0;
        res_valid    = 1'b0;
        arr_w_in_vec = '0;
        arr_a_in_vec = '0;
        if (!reset) begin
            busy      = (r_state != c_S_IDLE);
            done      = (r_state == c_S_DONE);
            w_ready   = (r_state == c_S_LOAD_W);
            a_ready   = (r_state == c_S_COMPUTE);
            arr_mode  = w_advance;
            res_valid = w_advance && r_tag[LATENCY-1];
            if (r_state == c_S_SHIFT_W)
                arr_w_in_vec = r_wbuf[c_ROW_LAST - r_shift_cnt];
            if (w_tag_in)
                arr_a_in_vec = a_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_vec_total <= '0;
            r_vec_cnt   <= '0;
            r_row_cnt   <= '0;
            r_shift_cnt <= '0;
            r_drain_cnt <= '0;
            r_tag       <= '0;
            for (int i = 0; i < ARRHEIGHT; i++)
                r_wbuf[i] <= '0;
        end else begin
            // The tag line moves in lockstep with the array, which only runs in compute mode.
            if (w_advance)
                r_tag <= LATENCY'({r_tag, w_tag_in});
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_vec_total <= num_vecs;
                        r_vec_cnt   <= '0;
                        r_row_cnt   <= '0;
                        r_state     <= c_S_LOAD_W;
                    end
                end
                c_S_LOAD_W: begin
                    if (w_valid) begin
                        r_wbuf[r_row_cnt] <= w_data;
                        if (r_row_cnt == c_ROW_LAST) begin
                            r_row_cnt   <= '0;
                            r_shift_cnt <= '0;
                            r_state     <= c_S_SHIFT_W;
                        end else begin
                            r_row_cnt <= r_row_cnt + c_IW'(1);
                        end
                    end
                end
                c_S_SHIFT_W: begin
                    if (r_shift_cnt == c_ROW_LAST) begin
                        r_shift_cnt <= '0;
                        r_state     <= (r_vec_total == '0) ? c_S_DONE : c_S_COMPUTE;
                    end else begin
                        r_shift_cnt <= r_shift_cnt + c_IW'(1);
                    end
                end
                c_S_COMPUTE: begin
                    if (a_valid) begin
                        r_vec_cnt <= r_vec_cnt + CNTWIDTH'(1);
                        if (r_vec_cnt + CNTWIDTH'(1) == r_vec_total) begin
                            r_drain_cnt <= '0;
                            r_state     <= c_S_DRAIN;
                        end
                    end
                end
                c_S_DRAIN: begin
                    if (r_drain_cnt == c_DRAIN_LAST)
                        r_state <= c_S_DONE;
                    else
                        r_drain_cnt <= r_drain_cnt + c_DW'(1);
                end
                c_S_DONE: r_state <= c_S_IDLE;
                default:  r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_ws_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_systolic_ws_controller
// Brief   : Randomized job-level bench with a timeline model and array model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_systolic_ws_controller;

    localparam int H = 8, WC = 8, WW = 8, L = 17, CW = 16;
    localparam int WROW = WW * WC, AVEC = WW * H, PSW = 4 * WW * WC;

    logic clk = 1'b0;
    logic reset = 1'b0, start = 1'b0, w_valid = 1'b0, a_valid = 1'b0;
    logic [CW-1:0]   num_vecs = '0;
    logic [WROW-1:0] w_data = '0;
    logic [AVEC-1:0] a_data = '0;
    logic busy, done, w_ready, a_ready, res_valid, arr_mode;
    logic [PSW-1:0]  res_data;
    logic [WROW-1:0] arr_w_in_vec;
    logic [AVEC-1:0] arr_a_in_vec;
    logic [PSW-1:0]  ps_model = '0;

    always #5 clk = ~clk;

    systolic_ws_controller #(.ARRWIDTH(WC), .ARRHEIGHT(H), .WORDWIDTH(WW),
                             .LATENCY(L), .CNTWIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_vecs(num_vecs),
        .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .res_valid(res_valid), .res_data(res_data),
        .arr_mode(arr_mode), .arr_w_in_vec(arr_w_in_vec),
        .arr_a_in_vec(arr_a_in_vec), .arr_ps_out_vec(ps_model)
    );

    typedef struct {
        logic rst, start; logic [CW-1:0] nv;
        logic wv; logic [WROW-1:0] wd; logic av; logic [AVEC-1:0] ad;
        logic busy, done, w_ready, a_ready, mode, resv;
        logic [WROW-1:0] w_in; logic [AVEC-1:0] a_in; logic [PSW-1:0] res;
    } cyc_t;

    cyc_t plan[$];
    cyc_t exp_q[$];
    int n_cmp = 0, n_fail = 0;
    int g_done_cyc, g_first_res, g_shift_start;

    task automatic chk(input string nm, input logic [PSW-1:0] act, input logic [PSW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @%0t: actual %0h required %0h", nm, $time, act, expv);
        end
    endtask

    function automatic logic [63:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    // Column c of the result is the dot product of the activation vector with weight column c.
    function automatic logic [PSW-1:0] matmul(input logic [H-1:0][WROW-1:0] w, input logic [AVEC-1:0] a);
        logic [PSW-1:0] r;
        logic [31:0] s;
        r = '0;
        for (int c = 0; c < WC; c++) begin
            s = 0;
            for (int i = 0; i < H; i++)
                s += 32'(a[i*WW +: WW]) * 32'(w[i][c*WW +: WW]);
            r[c*32 +: 32] = s;
        end
        return r;
    endfunction

    function automatic logic [AVEC-1:0] ramp(input int j);
        logic [AVEC-1:0] a;
        for (int i = 0; i < H; i++) a[i*WW +: WW] = WW'((i + 1) * (j + 1));
        return a;
    endfunction

    function automatic cyc_t idle_cyc();
        cyc_t e;
        e.rst = 1'b0; e.start = 1'b0; e.nv = CW'($urandom());
        e.wv = 1'($urandom()); e.wd = r64(); e.av = 1'($urandom()); e.ad = r64();
        e.busy = 1'b0; e.done = 1'b0; e.w_ready = 1'b0; e.a_ready = 1'b0;
        e.mode = 1'b0; e.resv = 1'b0; e.w_in = '0; e.a_in = '0; e.res = '0;
        return e;
    endfunction

    function automatic cyc_t job_cyc();
        cyc_t e;
        e = idle_cyc();
        e.busy = 1'b1;
        e.start = ($urandom_range(0, 3) == 0);
        return e;
    endfunction

    // wmode/amode: 0 = always valid, 1 = directed pattern, 2 = random.
    task automatic build_job(input int n, input int wmode, input int amode,
                             input bit ident, input bit use_ramp, input int abort);
        cyc_t e;
        logic [H-1:0][WROW-1:0] wt;
        logic [AVEC-1:0] acts[$];
        int acc_cyc[$];
        int rows, acc, k, idx;
        logic [4:0] apat;
        logic wv, av;
        apat = 5'b11001;
        plan.delete();
        g_first_res = -1; g_done_cyc = -1;
        for (int r = 0; r < H; r++) begin
            wt[r] = ident ? '0 : r64();
            if (ident) wt[r][r*WW +: WW] = 8'd1;
        end
        e = idle_cyc(); e.start = 1'b1; e.nv = CW'(n); plan.push_back(e);
        rows = 0; k = 0;
        while (rows < H) begin
            e = job_cyc(); e.w_ready = 1'b1;
            wv = (wmode == 0) ? 1'b1 : (wmode == 1) ? (k % 2 == 0) : ($urandom_range(0, 2) != 0);
            e.wv = wv;
            if (wv) begin e.wd = wt[rows]; rows++; end
            plan.push_back(e); k++;
        end
        g_shift_start = plan.size();
        for (int s = 0; s < H; s++) begin
            e = job_cyc(); e.w_in = wt[H-1-s]; plan.push_back(e);
        end
        if (n > 0) begin
            acc = 0; k = 0;
            while (acc < n) begin
                if (abort >= 0 && acc == abort) begin
                    e = idle_cyc(); e.rst = 1'b1; plan.push_back(e);
                    for (int i = 0; i < 20; i++) plan.push_back(idle_cyc());
                    return;
                end
                e = job_cyc(); e.mode = 1'b1; e.a_ready = 1'b1;
                av = (amode == 0) ? 1'b1 : (amode == 1) ? ((k < 5) ? apat[k] : 1'b1)
                                                       : ($urandom_range(0, 2) != 0);
                e.av = av;
                e.ad = use_ramp ? ramp(acc) : r64();
                if (av) begin
                    e.a_in = e.ad;
                    acts.push_back(e.ad);
                    acc_cyc.push_back(plan.size());
                    acc++;
                end
                plan.push_back(e); k++;
            end
            for (int d = 0; d < L; d++) begin
                e = job_cyc(); e.mode = 1'b1; plan.push_back(e);
            end
        end
        e = job_cyc(); e.done = 1'b1; g_done_cyc = plan.size(); plan.push_back(e);
        plan.push_back(idle_cyc());
        for (int j = 0; j < acts.size(); j++) begin
            idx = acc_cyc[j] + L;
            e = plan[idx]; e.resv = 1'b1; e.res = matmul(wt, acts[j]); plan[idx] = e;
        end
        if (acc_cyc.size() > 0) g_first_res = acc_cyc[0] + L;
    endtask

    task automatic run_plan();
        cyc_t e;
        for (int i = 0; i < plan.size(); i++) begin
            @(posedge clk); #1;
            e = plan[i];
            reset = e.rst; start = e.start; num_vecs = e.nv;
            w_valid = e.wv; w_data = e.wd; a_valid = e.av; a_data = e.ad;
            exp_q.push_back(e);
        end
    endtask

    // Array stand-in: weights land bottom row first, results emerge LATENCY compute cycles later.
    logic [H-1:0][WROW-1:0] arrw = '0;
    logic [AVEC-1:0] pipe [L] = '{default: '0};
    int sidx = 0;
    always @(posedge clk) begin
        if (arr_mode) begin
            for (int i = L - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = arr_a_in_vec;
        end
        if (busy && !arr_mode && !w_ready && !done) begin
            arrw[H-1-sidx] = arr_w_in_vec;
            sidx = (sidx + 1) % H;
        end
        if (reset) sidx = 0;
        ps_model = matmul(arrw, pipe[L-1]);
    end

    always @(negedge clk) begin
        cyc_t ce;
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk("busy", PSW'(busy), PSW'(ce.busy));
            chk("done", PSW'(done), PSW'(ce.done));
            chk("w_ready", PSW'(w_ready), PSW'(ce.w_ready));
            chk("a_ready", PSW'(a_ready), PSW'(ce.a_ready));
            chk("arr_mode", PSW'(arr_mode), PSW'(ce.mode));
            chk("res_valid", PSW'(res_valid), PSW'(ce.resv));
            chk("arr_w_in_vec", PSW'(arr_w_in_vec), PSW'(ce.w_in));
            chk("arr_a_in_vec", PSW'(arr_a_in_vec), PSW'(ce.a_in));
            if (ce.resv) chk("res_data", res_data, ce.res);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc_t e;
        plan.delete();
        for (int i = 0; i < 3; i++) begin e = idle_cyc(); e.rst = 1'b1; plan.push_back(e); end
        plan.push_back(idle_cyc());
        run_plan();

        // Identity weights, four ramp vectors back-to-back.
        build_job(4, 0, 0, 1'b1, 1'b1, -1);
        chk("pin_done_cyc", PSW'(g_done_cyc), PSW'(38));
        chk("pin_first_res", PSW'(g_first_res), PSW'(34));
        e = plan[34]; chk("pin_res_k1_e0", PSW'(e.res[31:0]), PSW'(1));
        e = plan[37]; chk("pin_res_k4_e7", PSW'(e.res[255:224]), PSW'(32));
        run_plan();

        build_job(3, 1, 0, 1'b0, 1'b0, -1);
        chk("pin_shift_start", PSW'(g_shift_start), PSW'(16));
        run_plan();

        build_job(3, 0, 1, 1'b0, 1'b0, -1);
        chk("pin_pat_done", PSW'(g_done_cyc), PSW'(39));
        chk("pin_pat_first_res", PSW'(g_first_res), PSW'(34));
        run_plan();

        build_job(0, 0, 0, 1'b0, 1'b0, -1);
        chk("pin_zero_done", PSW'(g_done_cyc), PSW'(17));
        run_plan();

        build_job(5, 0, 0, 1'b0, 1'b0, 2);
        run_plan();
        build_job(2, 2, 2, 1'b0, 1'b0, -1);
        run_plan();

        for (int j = 0; j < 8; j++) begin
            build_job($urandom_range(0, 7), 2, 2, 1'b0, 1'b0, -1);
            run_plan();
        end

        @(negedge clk); @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
